// File: rtl/pc_gen.sv
// pc_gen: program-counter register, next-PC select, circular return-address stack, RAS-hit counter.
// Latency: NPC/ras_hit/misalign combinational; PC, RAS and hit_cnt update one clk after the instruction.
// Backpressure: stall=1 freezes PC, RAS and hit_cnt for the cycle; NPC still reflects the selected target.
// Optional: define PC_MISALIGN_TRAP_EN to redirect misaligned targets to TRAP_VEC.
module pc_gen #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          RAS_DEPTH = 4,
  parameter int          HITCNT_W  = 16,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic [2:0]          NPCOp,
  input  logic [XLEN-1:0]     IMM,
  input  logic [XLEN-1:0]     ALUOut,
  input  logic                is_call,
  input  logic                is_ret,
  output logic [XLEN-1:0]     PC,
  output logic [XLEN-1:0]     NPC,
  output logic                ras_valid,
  output logic [XLEN-1:0]     ras_top,
  output logic                ras_hit,
  output logic                ras_ovf,
  output logic [HITCNT_W-1:0] hit_cnt,
  output logic                misalign
);

  localparam logic [2:0] OP_PLUS4  = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_JALR   = 3'b100;

  localparam int              PW       = $clog2(RAS_DEPTH);
  localparam logic [PW:0]     DEPTH_C  = (PW+1)'(RAS_DEPTH);
  localparam logic [XLEN-1:0] RESET_V  = XLEN'(RESET_PC);
  localparam logic [XLEN-1:0] TRAP_PC  = XLEN'(TRAP_VEC);

  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW:0]     count;

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] target;
  logic [PW-1:0]   top_idx;
  logic            is_jalr;
  logic            push;
  logic            pop;
  logic            upd;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;

  assign pc_plus4 = PC + XLEN'(4);
  assign jalr_tgt = ALUOut & ~XLEN'(1);
  assign is_jalr  = (NPCOp == OP_JALR);
  assign top_idx  = ptr - PW'(1);

  // Target select; unlisted encodings fall back to sequential fetch.
  always_comb begin
    target = pc_plus4;
    case (NPCOp)
      OP_BRANCH, OP_JUMP: target = PC + IMM;
      OP_JALR:            target = jalr_tgt;
      default:            target = pc_plus4;
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign misalign = (target[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign NPC       = misalign ? TRAP_PC : target;
  assign ras_valid = (count != '0);
  assign ras_top   = ras_valid ? ras_mem[top_idx] : '0;
  assign ras_hit   = is_ret & is_jalr & ras_valid & (ras_top == jalr_tgt);

  // A trapped redirect must not disturb the stack or statistics.
  assign upd  = ~stall & ~misalign;
  assign push = is_call & (is_jalr | (NPCOp == OP_JUMP));
  assign pop  = is_ret & is_jalr;

  // Stack write port: combined pop+push on a non-empty stack rewrites the top in place.
  always_comb begin
    wr_en  = upd & push;
    wr_idx = (pop && ras_valid) ? top_idx : ptr;
  end

  // PC register, stack pointer/occupancy, overflow flag and hit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      PC      <= RESET_V;
      ptr     <= '0;
      count   <= '0;
      ras_ovf <= 1'b0;
      hit_cnt <= '0;
    end else if (!stall) begin
      PC <= NPC;
      if (upd) begin
        if (push && pop) begin
          if (!ras_valid) begin
            ptr   <= ptr + PW'(1);
            count <= count + 1'b1;
          end
        end else if (push) begin
          ptr <= ptr + PW'(1);
          if (count == DEPTH_C) ras_ovf <= 1'b1;
          else                  count   <= count + 1'b1;
        end else if (pop && ras_valid) begin
          ptr   <= top_idx;
          count <= count - 1'b1;
        end
        if (ras_hit && (hit_cnt != '1)) hit_cnt <= hit_cnt + 1'b1;
      end
    end
  end

  // Stack storage; stale entries are masked by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) ras_mem[wr_idx] <= pc_plus4;
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed test of pc_gen against a queue-based behavioural model.
// Inputs driven 1 time unit after the rising edge; outputs compared mid-cycle.
// Summary line reports total comparisons and failures.
module tb_pc_gen;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, stall, is_call, is_ret;
  logic [2:0]  op;
  logic [31:0] imm, alu;
  logic [31:0] pc, npc, ras_top;
  logic        ras_valid, ras_hit, ras_ovf, misalign;
  logic [15:0] hit_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: the stack is a queue with the newest entry at the back.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  logic        m_ovf;
  logic [15:0] m_hit;

  // Model combinational results for the current inputs.
  logic [31:0] e_npc, e_top;
  logic        e_mis, e_valid, e_hit;

  pc_gen #(.XLEN(32), .RESET_PC(32'h0), .RAS_DEPTH(DEPTH), .HITCNT_W(16), .TRAP_VEC(32'h100)) dut (
    .clk(clk), .rst(rst), .stall(stall), .NPCOp(op), .IMM(imm), .ALUOut(alu),
    .is_call(is_call), .is_ret(is_ret), .PC(pc), .NPC(npc), .ras_valid(ras_valid),
    .ras_top(ras_top), .ras_hit(ras_hit), .ras_ovf(ras_ovf), .hit_cnt(hit_cnt), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic m_eval();
    logic [31:0] tgt;
    logic [31:0] jt;
    jt = alu & 32'hFFFF_FFFE;
    case (op)
      3'd1, 3'd2: tgt = m_pc + imm;
      3'd4:       tgt = jt;
      default:    tgt = m_pc + 32'd4;
    endcase
`ifdef PC_MISALIGN_TRAP_EN
    e_mis = (tgt % 4) != 0;
`else
    e_mis = 1'b0;
`endif
    e_npc   = e_mis ? 32'h100 : tgt;
    e_valid = m_ras.size() > 0;
    e_top   = e_valid ? m_ras[m_ras.size()-1] : 32'h0;
    e_hit   = is_ret && op == 3'd4 && e_valid && e_top == jt;
  endtask

  task automatic cmp();
    m_eval();
    chk("pc",        pc,        m_pc);
    chk("npc",       npc,       e_npc);
    chk("ras_valid", ras_valid, e_valid);
    chk("ras_top",   ras_top,   e_top);
    chk("ras_hit",   ras_hit,   e_hit);
    chk("ras_ovf",   ras_ovf,   m_ovf);
    chk("hit_cnt",   hit_cnt,   m_hit);
    chk("misalign",  misalign,  e_mis);
  endtask

  // Advance the model by one instruction, then let the DUT take the same edge.
  task automatic tick();
    logic [31:0] pc4;
    logic        psh, pp;
    m_eval();
    if (!stall) begin
      pc4  = m_pc + 32'd4;
      m_pc = e_npc;
      if (!e_mis) begin
        psh = is_call && (op == 3'd2 || op == 3'd4);
        pp  = is_ret && op == 3'd4;
        if (psh && pp && m_ras.size() > 0) m_ras[m_ras.size()-1] = pc4;
        else if (psh) begin
          m_ras.push_back(pc4);
          if (m_ras.size() > DEPTH) begin
            void'(m_ras.pop_front());
            m_ovf = 1'b1;
          end
        end else if (pp && m_ras.size() > 0) void'(m_ras.pop_back());
        if (e_hit && m_hit != 16'hFFFF) m_hit++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pre(input logic [2:0] o, input logic [31:0] i, input logic [31:0] a,
                     input logic c, input logic r, input logic s);
    op = o; imm = i; alu = a; is_call = c; is_ret = r; stall = s;
    #2;
    cmp();
  endtask

  task automatic step(input logic [2:0] o, input logic [31:0] i, input logic [31:0] a,
                      input logic c, input logic r, input logic s);
    pre(o, i, a, c, r, s);
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b1; op = 3'd4; alu = 32'h777; is_call = 1'b1; is_ret = 1'b0; imm = 32'h0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_pc = 32'h0; m_ras.delete(); m_ovf = 1'b0; m_hit = 16'h0;
  endtask

  initial begin
    do_reset();
    chk("reset_pc", pc, 32'h0);
    chk("reset_valid", ras_valid, 1'b0);

    // Sequential fetch.
    for (int k = 0; k < 3; k++) step(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("plus4_pc", pc, 32'hC);
    chk("plus4_hit", hit_cnt, 16'h0);

    // Backward branch.
    step(3'd4, 32'h0, 32'h100, 1'b0, 1'b0, 1'b0);
    pre(3'd1, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("branch_npc", npc, 32'hF0);
    tick();
    chk("branch_pc", pc, 32'hF0);

    // Wrap at top of the address space; unlisted opcode behaves as PLUS4.
    step(3'd4, 32'h0, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0);
    step(3'd7, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("wrap_pc", pc, 32'h0);

    // Call / return pair.
    step(3'd4, 32'h0, 32'h200, 1'b0, 1'b0, 1'b0);
    step(3'd2, 32'h100, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("call_top", ras_top, 32'h204);
    pre(3'd4, 32'h0, 32'h205, 1'b0, 1'b1, 1'b0);
    chk("ret_hit", ras_hit, 1'b1);
    chk("ret_npc", npc, 32'h204);
    tick();
    chk("ret_cnt", hit_cnt, 16'h1);
    chk("ret_empty", ras_valid, 1'b0);

    // Five calls overflow a four-deep stack.
    step(3'd4, 32'h0, 32'h10, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) step(3'd4, 32'h0, 32'((k + 1) * 16), 1'b1, 1'b0, 1'b0);
    chk("ovf", ras_ovf, 1'b1);
    for (int k = 0; k < 4; k++) begin
      pre(3'd4, 32'h0, 32'h54 - 32'(k * 16), 1'b0, 1'b1, 1'b0);
      chk("pop_top", ras_top, 32'h54 - 32'(k * 16));
      chk("pop_hit", ras_hit, 1'b1);
      tick();
    end
    pre(3'd4, 32'h0, 32'h14, 1'b0, 1'b1, 1'b0);
    chk("empty_pop_hit", ras_hit, 1'b0);
    tick();
    chk("empty_pop_valid", ras_valid, 1'b0);
    chk("pops_cnt", hit_cnt, 16'h5);

    // Stall holds state but NPC still shows the target.
    pre(3'd4, 32'h0, 32'h400, 1'b1, 1'b0, 1'b1);
    chk("stall_npc", npc, 32'h400);
    tick();
    chk("stall_pc", pc, 32'h14);
    chk("stall_valid", ras_valid, 1'b0);
    step(3'd4, 32'h0, 32'h400, 1'b1, 1'b0, 1'b0);
    chk("unstall_pc", pc, 32'h400);
    chk("unstall_top", ras_top, 32'h18);

    // Misaligned JALR target.
    pre(3'd4, 32'h0, 32'h302, 1'b1, 1'b0, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_flag", misalign, 1'b1);
    chk("mis_npc", npc, 32'h100);
    tick();
    chk("mis_top", ras_top, 32'h18);
`else
    chk("mis_flag", misalign, 1'b0);
    chk("mis_npc", npc, 32'h302);
    tick();
    chk("mis_top", ras_top, 32'h404);
`endif

    // Combined pop+push replaces the top; jump flags on a non-jump are ignored.
    step(3'd4, 32'h0, 32'h500, 1'b1, 1'b1, 1'b0);
`ifdef PC_MISALIGN_TRAP_EN
    chk("swap_top", ras_top, 32'h104);
`else
    chk("swap_top", ras_top, 32'h306);
`endif
    step(3'd0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    step(3'd1, 32'h8, 32'h0, 1'b1, 1'b0, 1'b0);

    // Reset with a populated stack and stall asserted.
    do_reset();
    chk("rst2_valid", ras_valid, 1'b0);
    chk("rst2_ovf", ras_ovf, 1'b0);
    chk("rst2_cnt", hit_cnt, 16'h0);
    chk("rst2_pc", pc, 32'h0);
    step(3'd0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
